// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg : opcode/funct codes, ALU operation codes and FSM state codes
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_pkg;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_slti  = 6'b001010;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;
  localparam logic [5:0] c_fn_nor = 6'b100111;

  localparam logic [3:0] c_alu_and  = 4'b0000;
  localparam logic [3:0] c_alu_or   = 4'b0001;
  localparam logic [3:0] c_alu_add  = 4'b0010;
  localparam logic [3:0] c_alu_sub  = 4'b0110;
  localparam logic [3:0] c_alu_slt  = 4'b0111;
  localparam logic [3:0] c_alu_nor  = 4'b1100;
  localparam logic [3:0] c_alu_none = 4'b1111;

  typedef enum logic [3:0] {
    c_st_fetch     = 4'd0,
    c_st_decode    = 4'd1,
    c_st_mem_addr  = 4'd2,
    c_st_mem_read  = 4'd3,
    c_st_mem_wb    = 4'd4,
    c_st_mem_write = 4'd5,
    c_st_exec_r    = 4'd6,
    c_st_alu_wb    = 4'd7,
    c_st_branch    = 4'd8,
    c_st_jump      = 4'd9,
    c_st_exec_i    = 4'd10,
    c_st_trap      = 4'd11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_func_decode.sv
// ---------------------------------------------------------------------------
// alu_func_decode : maps opcode/funct to an ALU operation and a legality flag
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_func_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit ENABLE_EXT = 1'b1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       supported
);

  always_comb begin
    alu_op    = c_alu_none;
    supported = 1'b0;
    case (opcode)
      c_op_rtype: begin
        case (funct)
          c_fn_add: begin alu_op = c_alu_add; supported = 1'b1; end
          c_fn_sub: begin alu_op = c_alu_sub; supported = 1'b1; end
          c_fn_and: begin alu_op = c_alu_and; supported = 1'b1; end
          c_fn_or:  begin alu_op = c_alu_or;  supported = 1'b1; end
          c_fn_slt: if (ENABLE_EXT) begin alu_op = c_alu_slt; supported = 1'b1; end
          c_fn_nor: if (ENABLE_EXT) begin alu_op = c_alu_nor; supported = 1'b1; end
          default: ;
        endcase
      end
      c_op_lw, c_op_sw: begin alu_op = c_alu_add; supported = 1'b1; end
      c_op_beq:  begin alu_op = c_alu_sub; supported = 1'b1; end
      c_op_j:    supported = 1'b1;
      c_op_addi: begin alu_op = c_alu_add; supported = 1'b1; end
      c_op_andi: if (ENABLE_EXT) begin alu_op = c_alu_and; supported = 1'b1; end
      c_op_ori:  if (ENABLE_EXT) begin alu_op = c_alu_or;  supported = 1'b1; end
      c_op_slti: if (ENABLE_EXT) begin alu_op = c_alu_slt; supported = 1'b1; end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl : main control FSM of the multicycle RISC core
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit ENABLE_EXT = 1'b1,
  parameter bit MEM_WAIT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic       w_ready;
  logic [3:0] w_alu_op;
  logic       w_supported;

  assign w_ready = MEM_WAIT ? mem_ready : 1'b1;

  alu_func_decode #(
    .ENABLE_EXT (ENABLE_EXT)
  ) u_alu_func_decode (
    .opcode    (opcode),
    .funct     (funct),
    .alu_op    (w_alu_op),
    .supported (w_supported)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= c_st_fetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = c_alu_none;
    case (state_q)
      c_st_fetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = c_alu_add;
        ir_write  = w_ready;
        pc_write  = w_ready;
        if (w_ready) state_d = c_st_decode;
      end
      c_st_decode: begin
        // Branch target is precomputed here while the opcode is dispatched
        alu_src_b = 2'b11;
        alu_op    = c_alu_add;
        if (!w_supported) state_d = c_st_trap;
        else begin
          case (opcode)
            c_op_rtype:       state_d = c_st_exec_r;
            c_op_lw, c_op_sw: state_d = c_st_mem_addr;
            c_op_beq:         state_d = c_st_branch;
            c_op_j:           state_d = c_st_jump;
            default:          state_d = c_st_exec_i;
          endcase
        end
      end
      c_st_mem_addr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = c_alu_add;
        state_d   = (opcode == c_op_lw) ? c_st_mem_read : c_st_mem_write;
      end
      c_st_mem_read: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (w_ready) state_d = c_st_mem_wb;
      end
      c_st_mem_wb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = c_st_fetch;
      end
      c_st_mem_write: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (w_ready) state_d = c_st_fetch;
      end
      c_st_exec_r, c_st_exec_i: begin
        alu_src_a = 1'b1;
        alu_src_b = (state_q == c_st_exec_i) ? 2'b10 : 2'b00;
        alu_op    = w_alu_op;
        state_d   = c_st_alu_wb;
      end
      c_st_alu_wb: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == c_op_rtype);
        state_d   = c_st_fetch;
      end
      c_st_branch: begin
        alu_src_a = 1'b1;
        alu_op    = c_alu_sub;
        pc_src    = 2'b01;
        pc_write  = zero;
        state_d   = c_st_fetch;
      end
      c_st_jump: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = c_st_fetch;
      end
      c_st_trap: state_d = c_st_trap;
      default:   state_d = c_st_trap;
    endcase
    // Nothing may be written or strobed while reset is held
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign illegal = (state_q == c_st_trap);
  assign state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl : directed scoreboard bench for multicycle_ctrl
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       m_pw, m_irw, m_mr, m_mw, m_io, m_rw, m_rd, m_m2r, m_sa, m_ill;
  logic [1:0] m_ps, m_sb;
  logic [3:0] m_op, m_st;
  logic       n_pw, n_irw, n_mr, n_mw, n_io, n_rw, n_rd, n_m2r, n_sa, n_ill;
  logic [1:0] n_ps, n_sb;
  logic [3:0] n_op, n_st;
  logic       w_pw, w_irw, w_mr, w_mw, w_io, w_rw, w_rd, w_m2r, w_sa, w_ill;
  logic [1:0] w_ps, w_sb;
  logic [3:0] w_op, w_st;

  int checks = 0;
  int errors = 0;
  bit ne_trap = 1'b0;
  bit nw_on = 1'b0;

  logic [21:0] exp_main_q[$];
  logic [21:0] exp_ne_q[$];
  logic [21:0] exp_nw_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.ENABLE_EXT(1'b1), .MEM_WAIT(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(m_pw), .pc_src(m_ps), .ir_write(m_irw), .mem_read(m_mr), .mem_write(m_mw),
    .iord(m_io), .reg_write(m_rw), .reg_dst(m_rd), .mem_to_reg(m_m2r), .alu_src_a(m_sa),
    .alu_src_b(m_sb), .alu_op(m_op), .illegal(m_ill), .state(m_st));

  multicycle_ctrl #(.ENABLE_EXT(1'b0), .MEM_WAIT(1'b1)) dut_ne (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(n_pw), .pc_src(n_ps), .ir_write(n_irw), .mem_read(n_mr), .mem_write(n_mw),
    .iord(n_io), .reg_write(n_rw), .reg_dst(n_rd), .mem_to_reg(n_m2r), .alu_src_a(n_sa),
    .alu_src_b(n_sb), .alu_op(n_op), .illegal(n_ill), .state(n_st));

  multicycle_ctrl #(.ENABLE_EXT(1'b1), .MEM_WAIT(1'b0)) dut_nw (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(1'b0),
    .pc_write(w_pw), .pc_src(w_ps), .ir_write(w_irw), .mem_read(w_mr), .mem_write(w_mw),
    .iord(w_io), .reg_write(w_rw), .reg_dst(w_rd), .mem_to_reg(w_m2r), .alu_src_a(w_sa),
    .alu_src_b(w_sb), .alu_op(w_op), .illegal(w_ill), .state(w_st));

  wire [21:0] obs_main = {m_pw, m_ps, m_irw, m_mr, m_mw, m_io, m_rw, m_rd, m_m2r, m_sa, m_sb, m_op, m_ill, m_st};
  wire [21:0] obs_ne   = {n_pw, n_ps, n_irw, n_mr, n_mw, n_io, n_rw, n_rd, n_m2r, n_sa, n_sb, n_op, n_ill, n_st};
  wire [21:0] obs_nw   = {w_pw, w_ps, w_irw, w_mr, w_mw, w_io, w_rw, w_rd, w_m2r, w_sa, w_sb, w_op, w_ill, w_st};

  // Expected control word for a given state, straight from the state table
  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic [5:0] opc,
                                          input logic [5:0] fn, input logic z, input logic rdy,
                                          input logic r, input logic ext);
    logic pw, irw, mr, mw, io, rw, rd, m2r, sa, ill;
    logic [1:0] ps, sb;
    logic [3:0] op;
    {pw, irw, mr, mw, io, rw, rd, m2r, sa, ill} = '0;
    ps = 2'b00; sb = 2'b00; op = 4'b1111;
    case (st)
      4'd0:  begin mr = 1'b1; sb = 2'b01; op = 4'b0010; irw = rdy; pw = rdy; end
      4'd1:  begin sb = 2'b11; op = 4'b0010; end
      4'd2:  begin sa = 1'b1; sb = 2'b10; op = 4'b0010; end
      4'd3:  begin mr = 1'b1; io = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mw = 1'b1; io = 1'b1; end
      4'd6: begin
        sa = 1'b1;
        case (fn)
          6'b100000: op = 4'b0010;
          6'b100010: op = 4'b0110;
          6'b100100: op = 4'b0000;
          6'b100101: op = 4'b0001;
          6'b101010: op = ext ? 4'b0111 : 4'b1111;
          6'b100111: op = ext ? 4'b1100 : 4'b1111;
          default:   op = 4'b1111;
        endcase
      end
      4'd7:  begin rw = 1'b1; rd = (opc == 6'b000000); end
      4'd8:  begin sa = 1'b1; op = 4'b0110; ps = 2'b01; pw = z; end
      4'd9:  begin pw = 1'b1; ps = 2'b10; end
      4'd10: begin
        sa = 1'b1; sb = 2'b10;
        case (opc)
          6'b001000: op = 4'b0010;
          6'b001100: op = ext ? 4'b0000 : 4'b1111;
          6'b001101: op = ext ? 4'b0001 : 4'b1111;
          6'b001010: op = ext ? 4'b0111 : 4'b1111;
          default:   op = 4'b1111;
        endcase
      end
      4'd11: ill = 1'b1;
      default: ;
    endcase
    if (r) begin pw = 1'b0; irw = 1'b0; mr = 1'b0; mw = 1'b0; rw = 1'b0; end
    return {pw, ps, irw, mr, mw, io, rw, rd, m2r, sa, sb, op, ill, st};
  endfunction

  // One clock cycle: push expectations for the current inputs, compare at negedge
  task automatic cyc(input logic [3:0] es, input string tag);
    logic [21:0] e;
    exp_main_q.push_back(exp_vec(es, opcode, funct, zero, mem_ready, rst, 1'b1));
    exp_ne_q.push_back(exp_vec(ne_trap ? 4'd11 : es, opcode, funct, zero, mem_ready, rst, 1'b0));
    if (nw_on) exp_nw_q.push_back(exp_vec(es, opcode, funct, zero, 1'b1, rst, 1'b1));
    @(negedge clk);
    e = exp_main_q.pop_front();
    checks++;
    assert (obs_main === e) else begin
      errors++;
      $error("FAIL %s main: observed=%h expected=%h", tag, obs_main, e);
    end
    e = exp_ne_q.pop_front();
    checks++;
    assert (obs_ne === e) else begin
      errors++;
      $error("FAIL %s no_ext: observed=%h expected=%h", tag, obs_ne, e);
    end
    if (nw_on) begin
      e = exp_nw_q.pop_front();
      checks++;
      assert (obs_nw === e) else begin
        errors++;
        $error("FAIL %s no_wait: observed=%h expected=%h", tag, obs_nw, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] opc, input logic [5:0] fn);
    opcode = opc;
    funct  = fn;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc(4'd0, "reset_fetch");
    rst = 1'b0;

    // add, with mem_ready wiggling outside memory states
    set_instr(6'b000000, 6'b100000);
    cyc(4'd0, "add_fetch");
    mem_ready = 1'b0;
    cyc(4'd1, "add_decode");
    cyc(4'd6, "add_exec");
    cyc(4'd7, "add_wb");
    mem_ready = 1'b1;

    // lw with two wait states in MEM_READ
    set_instr(6'b100011, 6'b000000);
    cyc(4'd0, "lw_fetch");
    cyc(4'd1, "lw_decode");
    cyc(4'd2, "lw_addr");
    mem_ready = 1'b0;
    cyc(4'd3, "lw_wait1");
    cyc(4'd3, "lw_wait2");
    mem_ready = 1'b1;
    cyc(4'd3, "lw_read");
    cyc(4'd4, "lw_wb");

    // beq taken then not taken
    set_instr(6'b000100, 6'b000000);
    zero = 1'b1;
    cyc(4'd0, "beq1_fetch");
    cyc(4'd1, "beq1_decode");
    cyc(4'd8, "beq1_branch");
    zero = 1'b0;
    cyc(4'd0, "beq0_fetch");
    cyc(4'd1, "beq0_decode");
    cyc(4'd8, "beq0_branch");

    // j with one fetch wait state
    set_instr(6'b000010, 6'b000000);
    mem_ready = 1'b0;
    cyc(4'd0, "j_fetch_wait");
    mem_ready = 1'b1;
    cyc(4'd0, "j_fetch");
    cyc(4'd1, "j_decode");
    cyc(4'd9, "j_jump");

    // extended ops: the no-extension instance traps after DECODE of slt
    set_instr(6'b000000, 6'b101010);
    cyc(4'd0, "slt_fetch");
    cyc(4'd1, "slt_decode");
    ne_trap = 1'b1;
    cyc(4'd6, "slt_exec");
    cyc(4'd7, "slt_wb");
    set_instr(6'b000000, 6'b100111);
    cyc(4'd0, "nor_fetch");
    cyc(4'd1, "nor_decode");
    cyc(4'd6, "nor_exec");
    cyc(4'd7, "nor_wb");
    set_instr(6'b001101, 6'b000000);
    cyc(4'd0, "ori_fetch");
    cyc(4'd1, "ori_decode");
    cyc(4'd10, "ori_exec");
    cyc(4'd7, "ori_wb");
    set_instr(6'b001010, 6'b000000);
    cyc(4'd0, "slti_fetch");
    cyc(4'd1, "slti_decode");
    cyc(4'd10, "slti_exec");
    cyc(4'd7, "slti_wb");

    // reset in the middle of a read wait
    set_instr(6'b100011, 6'b000000);
    cyc(4'd0, "lw2_fetch");
    cyc(4'd1, "lw2_decode");
    cyc(4'd2, "lw2_addr");
    mem_ready = 1'b0;
    cyc(4'd3, "lw2_wait");
    rst = 1'b1;
    cyc(4'd3, "lw2_rst_gated");
    ne_trap = 1'b0;
    cyc(4'd0, "rst_midwait");
    rst = 1'b0;
    mem_ready = 1'b1;

    // illegal opcode: absorbing trap, only reset leaves it
    set_instr(6'b111111, 6'b000000);
    cyc(4'd0, "bad_fetch");
    cyc(4'd1, "bad_decode");
    zero = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      cyc(4'd11, "trap_hold");
    end
    zero = 1'b0;
    mem_ready = 1'b1;
    rst = 1'b1;
    cyc(4'd11, "trap_rst_pending");
    nw_on = 1'b1;
    cyc(4'd0, "rst_from_trap");
    rst = 1'b0;

    // sw and lw with the no-wait instance whose mem_ready is tied low
    set_instr(6'b101011, 6'b000000);
    cyc(4'd0, "sw_fetch");
    cyc(4'd1, "sw_decode");
    cyc(4'd2, "sw_addr");
    cyc(4'd5, "sw_write");
    set_instr(6'b100011, 6'b000000);
    cyc(4'd0, "lw3_fetch");
    cyc(4'd1, "lw3_decode");
    cyc(4'd2, "lw3_addr");
    cyc(4'd3, "lw3_read");
    cyc(4'd4, "lw3_wb");
    cyc(4'd0, "end_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
